// File: rtl/div_seq_8by4_pkg.sv
// Shared definitions for the sequential 8-by-4 restoring divider:
// default operand widths and the controller state encodings.
package div_seq_8by4_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned VW_DEF = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/div_seq_8by4_step.sv
// One combinational restoring-division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference if it fits.
module div_seq_8by4_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW-1:0] r,
    input  logic          qmsb,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] r_next,
    output logic          qbit
);

    logic [VW:0] shifted;
    logic [VW:0] trial;

    // The remainder is always below the divisor, so the result never needs the top bit.
    always_comb begin
        shifted = {r, qmsb};
        trial   = shifted - {1'b0, divisor};
        qbit    = ~trial[VW];
        r_next  = qbit ? trial[VW-1:0] : shifted[VW-1:0];
    end

endmodule

// File: rtl/div_seq_8by4.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// results and divide-by-zero flag held until the next completion.
module div_seq_8by4
    import div_seq_8by4_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [VW-1:0] r_next;
    logic          qbit;

    div_seq_8by4_step #(
        .VW(VW)
    ) u_step (
        .r      (r_q),
        .qmsb   (q_q[DW-1]),
        .divisor(dvs_q),
        .r_next (r_next),
        .qbit   (qbit)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            // FIN accepts a new request exactly like IDLE, allowing back-to-back operations.
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    q_d   = dividend;
                    dvs_d = divisor;
                    cnt_d = '0;
                    r_d   = '0;
                    if (divisor == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        quo_d   = {DW{1'b1}};
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                q_d   = {q_q[DW-2:0], qbit};
                r_d   = r_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    quo_d   = {q_q[DW-2:0], qbit};
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
